cursor_nav: RTL and testbench
=============================

CURSOR_NAV -- requirements
Module: cursor_nav

Interface
REQ-001 The module SHALL have parameter GRID_SIZE, default 9, meaning the side length of the square grid (cells = GRID_SIZE*GRID_SIZE).
REQ-002 The module SHALL have parameter CW, default 4, meaning the row/column index width; CW SHALL be at least clog2(GRID_SIZE).
REQ-003 Port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: move  input  1  move request level from the game controller; may stay high for many cycles.
REQ-006 Port: dir  input  2  move direction: 00 right, 01 up, 10 left, 11 down.
REQ-007 Port: bombGrid  input  GRID_SIZE*GRID_SIZE  bomb map; bit index = row*GRID_SIZE+col; row 0 is the top row.
REQ-008 Port: cursorGrid  output  GRID_SIZE*GRID_SIZE  one-hot cursor position, registered.
REQ-009 Port: curRow, curCol  output  CW each  cursor row and column, registered.
REQ-010 Port: adjCount  output  4  number of bombs in the 8 cells neighbouring the cursor, registered.
REQ-011 Port: adjValid  output  1  high when adjCount is valid for the current cursor position.

Function
REQ-012 A move step SHALL be taken only on a rising edge of move: move high at the current clock edge and low at the previous edge (registered move_q); a held level SHALL yield exactly one step.
REQ-013 On a step, the cursor SHALL update at that same clock edge: right col+1, left col-1, up row-1, down row+1.
REQ-014 Boundary: a step that would leave the grid SHALL be clamped (no wrap-around); the cursor stays unchanged, the edge is consumed, and no rescan is started.
REQ-015 cursorGrid SHALL always equal the one-hot of curRow*GRID_SIZE+curCol, updating at the same edge as curRow/curCol.
REQ-016 The scan FSM SHALL have states IDLE, SCAN and DONE; an unused encoding SHALL return to IDLE at the next edge.
REQ-017 At the edge E where the cursor changes, or the first edge after reset deasserts, the FSM SHALL enter SCAN with k=0 and acc=0, and adjValid SHALL go low at that edge.
REQ-018 SCAN SHALL process one neighbour per cycle at edges E+1..E+8, k = 0 NW, 1 N, 2 NE, 3 W, 4 E, 5 SW, 6 S, 7 SE, adding that neighbour's bombGrid bit to acc.
REQ-019 A neighbour outside the grid SHALL contribute 0; the cursor cell itself SHALL never be counted.
REQ-020 At edge E+8, the FSM SHALL load adjCount with the final sum (range 0..8) and set adjValid to 1, then move to DONE; total latency from cursor change to adjValid is 8 cycles.
REQ-021 During SCAN, adjCount SHALL hold its previous value.
REQ-022 A valid step arriving during SCAN SHALL update the cursor and restart the scan (k=0, acc=0) at that edge.
REQ-023 A clamped step arriving during SCAN SHALL not disturb the scan in progress.
REQ-024 DONE SHALL hold adjCount and adjValid until the next cursor change.
REQ-025 bombGrid SHALL be sampled live during SCAN; changes to bombGrid while in DONE SHALL not trigger a rescan.
REQ-026 dir SHALL be sampled only at the step edge; dir changes while move is held SHALL have no effect.

Reset
REQ-027 While reset is high at a clock edge, the module SHALL set: curRow=0, curCol=0, cursorGrid=1 (bit 0 only), adjCount=0, adjValid=0, FSM=IDLE, k=0, acc=0, move_q=1.
REQ-028 Initialising move_q to 1 SHALL prevent a move held through reset release from producing a step.
REQ-029 Reset asserted mid-scan SHALL abort the scan, and the outputs SHALL take the reset values at that edge.
REQ-030 After reset release, the module SHALL perform a scan for cell (0,0) per REQ-017..REQ-020.

Verification
REQ-031 Reset release, GRID_SIZE=9, bombs at indices 8,17,26,35,44,53,62,71, move=0 -> cursorGrid=1, adjValid low 8 cycles then high with adjCount=0.
REQ-032 Seven right pulses from (0,0), each 1 cycle high then 12 cycles low -> curCol=7, cursorGrid bit 7 set, adjCount=2 (cells 8 and 17), adjValid high.
REQ-033 At (0,0), move held high 6 cycles with dir=10 (left), then dir=11 (down) pulses -> first: no change, adjValid stays 1; each down pulse: row+1, single step.
REQ-034 Right pulse then second right pulse 3 cycles later (mid-scan) -> curCol=2, adjValid low until 8 cycles after second step, adjCount for (0,2).
REQ-035 Reset pulsed mid-scan at cursor (4,4) -> cursor (0,0), adjValid=0 at that edge, then valid 8 cycles after release.
REQ-036 All 8 neighbours of (4,4) bombed -> adjCount=8; corner (8,8) with all grid bits set -> adjCount=3.

Source files
------------

// File: rtl/cursor_nav.sv
// Grid cursor driven by move-request edges, with an 8-cycle scan that counts
// bombs in the cells surrounding the cursor.
module cursor_nav #(
   parameter int GRID_SIZE = 9,
   parameter int CW        = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           move,
   input  logic [1:0]                     dir,
   input  logic [GRID_SIZE*GRID_SIZE-1:0] bombGrid,
   output logic [GRID_SIZE*GRID_SIZE-1:0] cursorGrid,
   output logic [CW-1:0]                  curRow,
   output logic [CW-1:0]                  curCol,
   output logic [3:0]                     adjCount,
   output logic                           adjValid
);
   localparam int            CELLS = GRID_SIZE * GRID_SIZE;
   localparam int            IW    = $clog2(CELLS);
   localparam logic [CW-1:0] LAST  = CW'(GRID_SIZE - 1);

   typedef enum logic [1:0] {IDLE = 2'b00, SCAN = 2'b01, DONE = 2'b10} state_t;
   typedef enum logic [1:0] {RIGHT = 2'b00, UP = 2'b01, LEFT = 2'b10, DOWN = 2'b11} dir_t;

   state_t           state, state_next;
   logic             move_q;
   logic [2:0]       k, k_next;
   logic [3:0]       acc, acc_next;
   logic [3:0]       count_next;
   logic             valid_next;
   logic [CW-1:0]    row_tgt, col_tgt;
   logic             step_ok;
   logic [CELLS-1:0] grid_next;
   logic             nbr_bit;
   logic [IW-1:0]    nbr_idx;
   int               dr, dc, nr, nc;

   // A step is an accepted move edge that stays inside the grid.
   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      row_tgt = curRow;
      col_tgt = curCol;
      step_ok = 1'b0;
      if (move && !move_q) begin
         case (dir_t'(dir))
            RIGHT: if (curCol != LAST) begin col_tgt = curCol + CW'(1); step_ok = 1'b1; end
            UP:    if (curRow != '0)   begin row_tgt = curRow - CW'(1); step_ok = 1'b1; end
            LEFT:  if (curCol != '0)   begin col_tgt = curCol - CW'(1); step_ok = 1'b1; end
            DOWN:  if (curRow != LAST) begin row_tgt = curRow + CW'(1); step_ok = 1'b1; end
            default: ;
         endcase
      end
      grid_next = CELLS'(1) << (int'(row_tgt) * GRID_SIZE + int'(col_tgt));
   end

   always_comb begin
      dr = 0;
      dc = 0;
      case (k)
         3'd0: begin dr = -1; dc = -1; end
         3'd1: begin dr = -1; dc =  0; end
         3'd2: begin dr = -1; dc =  1; end
         3'd3: begin dr =  0; dc = -1; end
         3'd4: begin dr =  0; dc =  1; end
         3'd5: begin dr =  1; dc = -1; end
         3'd6: begin dr =  1; dc =  0; end
         default: begin dr = 1; dc = 1; end
      endcase
      nr      = int'(curRow) + dr;
      nc      = int'(curCol) + dc;
      nbr_idx = '0;
      nbr_bit = 1'b0;
      if (nr >= 0 && nr < GRID_SIZE && nc >= 0 && nc < GRID_SIZE) begin
         nbr_idx = IW'(nr * GRID_SIZE + nc);
         nbr_bit = bombGrid[nbr_idx];
      end
   end

   always_comb begin
      state_next = state;
      k_next     = k;
      acc_next   = acc;
      count_next = adjCount;
      valid_next = adjValid;
      if (step_ok || state == IDLE) begin
         state_next = SCAN;
         k_next     = '0;
         acc_next   = '0;
         valid_next = 1'b0;
      end else begin
         case (state)
            SCAN: begin
               acc_next = acc + {3'b000, nbr_bit};
               k_next   = k + 3'd1;
               if (k == 3'd7) begin
                  count_next = acc_next;
                  valid_next = 1'b1;
                  state_next = DONE;
               end
            end
            DONE:    ;
            default: state_next = IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         move_q     <= 1'b1;
         k          <= '0;
         acc        <= '0;
         curRow     <= '0;
         curCol     <= '0;
         cursorGrid <= CELLS'(1);
         adjCount   <= '0;
         adjValid   <= 1'b0;
      end else begin
         state      <= state_next;
         move_q     <= move;
         k          <= k_next;
         acc        <= acc_next;
         curRow     <= row_tgt;
         curCol     <= col_tgt;
         cursorGrid <= grid_next;
         adjCount   <= count_next;
         adjValid   <= valid_next;
      end
   end
endmodule

// File: tb/tb_cursor_nav.sv
// Scoreboard bench for cursor_nav: stimulus queues the expected scan result,
// a monitor checks each rising edge of adjValid against the queue head.
module tb_cursor_nav;
   localparam int G     = 9;
   localparam int CELLS = G * G;
   localparam int CW    = 4;

   typedef struct {
      int row;
      int col;
      int count;
      int cyc;
   } exp_t;

   logic             clock;
   logic             reset;
   logic             move;
   logic [1:0]       dir;
   logic [CELLS-1:0] bombGrid;
   logic [CELLS-1:0] cursorGrid;
   logic [CW-1:0]    curRow;
   logic [CW-1:0]    curCol;
   logic [3:0]       adjCount;
   logic             adjValid;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc        = 0;
   int   n_checks   = 0;
   int   n_fail     = 0;
   logic prev_valid = 1'b0;

   cursor_nav #(.GRID_SIZE(G), .CW(CW)) dut (
      .clock      (clock),
      .reset      (reset),
      .move       (move),
      .dir        (dir),
      .bombGrid   (bombGrid),
      .cursorGrid (cursorGrid),
      .curRow     (curRow),
      .curCol     (curCol),
      .adjCount   (adjCount),
      .adjValid   (adjValid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] actual, input logic [127:0] required);
      n_checks++;
      if (actual !== required) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, actual, required);
      end
   endtask

   function automatic logic [CELLS-1:0] bit_at(input int i);
      return {{(CELLS-1){1'b0}}, 1'b1} << i;
   endfunction

   // Monitor: every adjValid rise must match the oldest queued expectation.
   always @(negedge clock) begin
      if (adjValid === 1'b1 && prev_valid !== 1'b1) begin
         check("pending_expectation", 128'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("rise_cycle", cyc, mon_e.cyc);
            check("scan_row", curRow, mon_e.row);
            check("scan_col", curCol, mon_e.col);
            check("scan_count", adjCount, mon_e.count);
            check("scan_grid", cursorGrid, bit_at(mon_e.row * G + mon_e.col));
         end
      end
      prev_valid = adjValid;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Called at the negedge where the triggering input is driven: the trigger
   // edge is the next posedge, and adjValid rises 8 edges after it.
   task automatic expect_scan(input int r, input int c, input int cnt);
      exp_t e;
      e = '{row: r, col: c, count: cnt, cyc: cyc + 9};
      sb.push_back(e);
   endtask

   task automatic pulse(input logic [1:0] d, input int hold, input int low);
      dir  = d;
      move = 1'b1;
      tick(hold);
      move = 1'b0;
      tick(low);
   endtask

   task automatic drain(input string name);
      int budget = 40;
      while (sb.size() != 0 && budget > 0) begin
         tick(1);
         budget--;
      end
      check({name, "_drained"}, sb.size(), 0);
   endtask

   task automatic apply_reset(input int cycles, input int cnt00);
      reset = 1'b1;
      tick(cycles);
      check("rst_row", curRow, 0);
      check("rst_col", curCol, 0);
      check("rst_grid", cursorGrid, bit_at(0));
      check("rst_count", adjCount, 0);
      check("rst_valid", adjValid, 0);
      reset = 1'b0;
      expect_scan(0, 0, cnt00);
   endtask

   initial begin
      reset    = 1'b1;
      move     = 1'b0;
      dir      = 2'b00;
      bombGrid = '0;
      for (int r = 0; r < 8; r++) bombGrid = bombGrid | bit_at(r * G + 8);
      @(negedge clock);

      // Reset release with the column-8 bomb map: scan of (0,0) reports 0.
      apply_reset(3, 0);
      tick(4);
      check("scan_in_progress_valid", adjValid, 0);
      drain("reset_scan");

      // Left held at the corner: clamped, consumed once, result undisturbed.
      dir  = 2'b10;
      move = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         check("hold_left_col", curCol, 0);
         check("hold_left_valid", adjValid, 1);
      end
      move = 1'b0;
      tick(2);
      pulse(2'b01, 1, 3);
      check("clamp_up_row", curRow, 0);
      check("clamp_up_valid", adjValid, 1);

      // Down held for 3 cycles, dir flipped mid-hold: exactly one down step each.
      for (int i = 1; i <= 2; i++) begin
         dir  = 2'b11;
         move = 1'b1;
         expect_scan(i, 0, 0);
         tick(1);
         dir = 2'b00;
         tick(2);
         move = 1'b0;
         check("down_row", curRow, i);
         check("down_col", curCol, 0);
         tick(10);
         drain("down_scan");
      end

      // Move held high through reset release must not step.
      dir  = 2'b00;
      move = 1'b1;
      apply_reset(2, 0);
      tick(1);
      check("held_thru_reset_col", curCol, 0);
      tick(3);
      check("held_thru_reset_col_late", curCol, 0);
      move = 1'b0;
      drain("held_reset_scan");

      // Seven right pulses along row 0; (0,7) touches bombs 8 and 17.
      for (int c = 1; c <= 7; c++) begin
         expect_scan(0, c, (c == 7) ? 2 : 0);
         pulse(2'b00, 1, 12);
      end
      drain("right_walk");
      check("walk_col", curCol, 7);
      check("walk_row", curRow, 0);
      check("walk_grid", cursorGrid, bit_at(7));
      check("walk_count", adjCount, 2);
      check("walk_valid", adjValid, 1);

      // Second right step 3 cycles into the first scan restarts it.
      bombGrid = bit_at(1) | bit_at(10) | bit_at(12);
      apply_reset(2, 2);
      drain("restart_reset_scan");
      dir  = 2'b00;
      move = 1'b1;
      tick(1);
      move = 1'b0;
      check("mid_first_valid", adjValid, 0);
      check("mid_first_col", curCol, 1);
      tick(2);
      move = 1'b1;
      expect_scan(0, 2, 3);
      tick(1);
      move = 1'b0;
      tick(12);
      drain("restart_scan");
      check("restart_col", curCol, 2);
      check("restart_count", adjCount, 3);

      // Bomb map changes while DONE must not trigger a rescan.
      bombGrid = '0;
      tick(10);
      check("done_hold_valid", adjValid, 1);
      check("done_hold_count", adjCount, 3);

      // Walk to (4,4) with an empty map, then bomb all its neighbours and itself.
      expect_scan(0, 3, 0); pulse(2'b00, 1, 12);
      expect_scan(0, 4, 0); pulse(2'b00, 1, 12);
      for (int r = 1; r <= 3; r++) begin
         expect_scan(r, 4, 0);
         pulse(2'b11, 1, 12);
      end
      drain("walk_to_3_4");
      bombGrid = bit_at(30) | bit_at(31) | bit_at(32) | bit_at(39) | bit_at(40)
               | bit_at(41) | bit_at(48) | bit_at(49) | bit_at(50);
      expect_scan(4, 4, 8);
      pulse(2'b11, 1, 12);
      drain("full_ring");
      expect_scan(4, 5, 5);
      pulse(2'b00, 1, 12);
      drain("right_of_ring");

      // Back to (4,4), then reset pulsed mid-scan.
      pulse(2'b10, 1, 2);
      check("pre_abort_col", curCol, 4);
      check("pre_abort_valid", adjValid, 0);
      apply_reset(1, 0);
      tick(4);
      check("post_abort_valid", adjValid, 0);
      drain("abort_scan");

      // Fast steps to the far corner; only the last scan completes.
      bombGrid = '1;
      for (int i = 0; i < 8; i++) pulse(2'b00, 1, 1);
      for (int i = 0; i < 7; i++) pulse(2'b11, 1, 1);
      expect_scan(8, 8, 3);
      pulse(2'b11, 1, 12);
      drain("corner");
      check("corner_row", curRow, 8);
      check("corner_col", curCol, 8);

      pulse(2'b00, 1, 2);
      check("clamp_right_col", curCol, 8);
      check("clamp_right_valid", adjValid, 1);
      pulse(2'b11, 1, 2);
      check("clamp_down_row", curRow, 8);
      check("clamp_down_valid", adjValid, 1);
      check("clamp_down_count", adjCount, 3);

      bombGrid = '0;
      tick(10);
      check("final_valid", adjValid, 1);
      check("final_count", adjCount, 3);
      check("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1);
   end
endmodule
